mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between the core's instruction fetch port (im_*) and
//  load/store port (dm_*), so program and data can live in one SRAM. Sits between core and memory.
//  Fixed priority data > fetch, with a starvation limit for fetch. At most one read outstanding.
// PARAMETERS
//  ADDR_WIDTH    32  address width of all ports
//  DATA_WIDTH    32  data width of all ports
//  MEM_LATENCY   1   cycles from mem_req_o to valid mem_rdata_i (>=1)
//  STARVE_LIMIT  4   consecutive fetch losses before fetch is forced to win (>=1)
// PORTS
//  clk_i        in   1             clock, all state on rising edge
//  rst_n_i      in   1             asynchronous active-low reset
//  im_req_i     in   1             fetch read request; hold with im_addr_i until im_gnt_o
//  im_addr_i    in   ADDR_WIDTH    fetch address
//  im_gnt_o     out  1             fetch request accepted this cycle
//  im_rvalid_o  out  1             im_rdata_o valid (1-cycle pulse)
//  im_rdata_o   out  DATA_WIDTH    fetch read data, 0 when im_rvalid_o low
//  dm_req_i     in   1             data request; hold with all dm_* fields until dm_gnt_o
//  dm_we_i      in   1             1 = write, 0 = read
//  dm_be_i      in   DATA_WIDTH/8  write byte enables
//  dm_addr_i    in   ADDR_WIDTH    data address
//  dm_wdata_i   in   DATA_WIDTH    write data
//  dm_gnt_o     out  1             data request accepted this cycle
//  dm_rvalid_o  out  1             dm_rdata_o valid (1-cycle pulse, reads only)
//  dm_rdata_o   out  DATA_WIDTH    load data, 0 when dm_rvalid_o low
//  mem_req_o    out  1             memory access strobe
//  mem_we_o     out  1             memory write enable
//  mem_be_o     out  DATA_WIDTH/8  memory byte enables (all ones for reads)
//  mem_addr_o   out  ADDR_WIDTH    memory address
//  mem_wdata_o  out  DATA_WIDTH    memory write data
//  mem_rdata_i  in   DATA_WIDTH    memory read data, valid MEM_LATENCY cycles after mem_req_o
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, starve counter 0, owner cleared; every output 0.
//  - FSM: IDLE, WAIT. Grants issue only when state is IDLE or WAIT is in its final cycle.
//  - Arbitration (combinational, same cycle): winner = dm if dm_req_i and starve_cnt<STARVE_LIMIT,
//    else im if im_req_i, else dm if dm_req_i. Only one gnt is high per cycle.
//  - Winner's fields drive mem_* combinationally in the grant cycle. mem_* = 0 when no grant.
//  - Grant of a read: owner<=winner, wait_cnt<=MEM_LATENCY-1, state->WAIT.
//  - Grant of a dm write: completes in grant cycle. State stays/returns IDLE. No rvalid pulse.
//  - WAIT: decrements wait_cnt each cycle. When wait_cnt==0: owner's rvalid=1,
//    owner's rdata=mem_rdata_i. State->IDLE unless a new read is granted that same cycle.
//    Result: read rvalid exactly MEM_LATENCY cycles after gnt; MEM_LATENCY=1 gives 1 access/cycle.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) each grant cycle where im_req_i=1 and dm wins.
//    Cleared when im granted or im_req_i=0.
//  - Request dropped before gnt: treated as withdrawn, no side effects.
//  - Request fields changed before gnt: protocol violation, undefined.
//  - Async reset mid-WAIT: pending read discarded; no rvalid after reset release.
//  - Counter widths: $clog2(MEM_LATENCY+1) and $clog2(STARVE_LIMIT+1).
// TESTING
//  1 Assert rst_n_i mid-run -> all outputs 0 immediately; starve counter 0 after release.
//  2 MEM_LATENCY=2, im_req_i at cycle T with addr 0x100 -> im_gnt_o and mem_addr_o=0x100 at T;
//    no gnt at T+1; im_rvalid_o at T+2 with im_rdata_o=mem_rdata_i.
//  3 im and dm read requests both at T -> dm_gnt_o at T; im_gnt_o at T+MEM_LATENCY
//    (the cycle dm_rvalid_o pulses).
//  4 STARVE_LIMIT=4, dm writes held continuously, im_req_i held -> dm granted 4 cycles,
//    im_gnt_o on 5th; dm resumes next cycle.
//  5 Back-to-back dm writes 0xA5 to addrs 0..7 with be=4'b0011 -> gnt every cycle,
//    mem_we_o=1, mem_be_o=4'b0011, no dm_rvalid_o.
//  6 MEM_LATENCY=3, read granted at T, reset pulsed at T+1 -> no rvalid at T+3; next request
//    granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (im_*) and load/store (dm_*).
// Data has fixed priority; fetch is forced through after STARVE_LIMIT consecutive losses.
//
// state  | meaning
// IDLE   | no read outstanding, grants allowed
// WAIT   | read outstanding; grants allowed only in the final cycle (r_wait_cnt == 0)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    im_req_i,
  input  logic [ADDR_WIDTH-1:0]   im_addr_i,
  output logic                    im_gnt_o,
  output logic                    im_rvalid_o,
  output logic [DATA_WIDTH-1:0]   im_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int WW = $clog2(MEM_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        r_state, w_state_nxt;
  logic [WW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [SW-1:0] r_starve_cnt, w_starve_cnt_nxt;
  logic          r_owner_dm, w_owner_dm_nxt;

  logic w_wait_last, w_can_grant, w_starved;
  logic w_dm_win, w_im_win, w_read_gnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= ST_IDLE;
      r_wait_cnt   <= '0;
      r_starve_cnt <= '0;
      r_owner_dm   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_owner_dm   <= w_owner_dm_nxt;
    end
  end

  // Grants are gated by rst_n_i so every output is low while reset is held.
  always_comb begin
    w_wait_last = (r_state == ST_WAIT) && (r_wait_cnt == '0);
    w_can_grant = rst_n_i && ((r_state == ST_IDLE) || w_wait_last);
    w_starved   = (r_starve_cnt >= STARVE_MAX);
    w_dm_win    = w_can_grant && dm_req_i && (!w_starved || !im_req_i);
    w_im_win    = w_can_grant && im_req_i && !w_dm_win;
    w_read_gnt  = w_im_win || (w_dm_win && !dm_we_i);
  end

  always_comb begin
    im_gnt_o    = w_im_win;
    dm_gnt_o    = w_dm_win;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_dm_win) begin
      mem_req_o   = 1'b1;
      mem_we_o    = dm_we_i;
      mem_be_o    = dm_we_i ? dm_be_i : {BW{1'b1}};
      mem_addr_o  = dm_addr_i;
      mem_wdata_o = dm_wdata_i;
    end else if (w_im_win) begin
      mem_req_o   = 1'b1;
      mem_be_o    = {BW{1'b1}};
      mem_addr_o  = im_addr_i;
    end
  end

  always_comb begin
    im_rvalid_o = w_wait_last && !r_owner_dm;
    dm_rvalid_o = w_wait_last && r_owner_dm;
    im_rdata_o  = im_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : '0;
  end

  // A read granted in WAIT's final cycle chains straight into the next WAIT.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_owner_dm_nxt = r_owner_dm;
    if (w_read_gnt) begin
      w_state_nxt    = ST_WAIT;
      w_wait_cnt_nxt = WAIT_INIT;
      w_owner_dm_nxt = w_dm_win;
    end else if (w_wait_last) begin
      w_state_nxt    = ST_IDLE;
    end else if (r_state == ST_WAIT) begin
      w_wait_cnt_nxt = r_wait_cnt - WW'(1);
    end
  end

  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (!im_req_i || w_im_win) begin
      w_starve_cnt_nxt = '0;
    end else if (w_dm_win && !w_starved) begin
      w_starve_cnt_nxt = r_starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (latency 2) runs a vector table plus a
// reset/starvation sequence, instance B (latency 3) covers reset during an outstanding read.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: MEM_LATENCY=2 ----------------
  logic        a_rst_n = 1'b0;
  logic        a_im_req = 1'b0, a_dm_req = 1'b0, a_dm_we = 1'b0;
  logic [31:0] a_im_addr = '0, a_dm_addr = '0, a_dm_wdata = '0;
  logic [3:0]  a_dm_be = '0;
  logic        a_im_gnt, a_im_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_req, a_mem_we;
  logic [31:0] a_im_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;
  logic [31:0] pa [2] = '{32'h0, 32'h0};

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut_a (
    .clk_i(clk), .rst_n_i(a_rst_n),
    .im_req_i(a_im_req), .im_addr_i(a_im_addr), .im_gnt_o(a_im_gnt),
    .im_rvalid_o(a_im_rvalid), .im_rdata_o(a_im_rdata),
    .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_be_i(a_dm_be), .dm_addr_i(a_dm_addr),
    .dm_wdata_i(a_dm_wdata), .dm_gnt_o(a_dm_gnt), .dm_rvalid_o(a_dm_rvalid), .dm_rdata_o(a_dm_rdata),
    .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_be_o(a_mem_be), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  // Memory model: returns addr ^ 0xC0DE0000 for the address presented two cycles earlier.
  always @(posedge clk) begin
    pa[0] <= a_mem_addr;
    pa[1] <= pa[0];
  end
  assign a_mem_rdata = pa[1] ^ 32'hC0DE_0000;

  // ---------------- instance B: MEM_LATENCY=3 ----------------
  logic        b_rst_n = 1'b0;
  logic        b_im_req = 1'b0, b_dm_req = 1'b0, b_dm_we = 1'b0;
  logic [31:0] b_im_addr = '0, b_dm_addr = '0, b_dm_wdata = '0;
  logic [3:0]  b_dm_be = '0;
  logic        b_im_gnt, b_im_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_req, b_mem_we;
  logic [31:0] b_im_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;
  logic [31:0] pb [3] = '{32'h0, 32'h0, 32'h0};

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(b_rst_n),
    .im_req_i(b_im_req), .im_addr_i(b_im_addr), .im_gnt_o(b_im_gnt),
    .im_rvalid_o(b_im_rvalid), .im_rdata_o(b_im_rdata),
    .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_be_i(b_dm_be), .dm_addr_i(b_dm_addr),
    .dm_wdata_i(b_dm_wdata), .dm_gnt_o(b_dm_gnt), .dm_rvalid_o(b_dm_rvalid), .dm_rdata_o(b_dm_rdata),
    .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_be_o(b_mem_be), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  always @(posedge clk) begin
    pb[0] <= b_mem_addr;
    pb[1] <= pb[0];
    pb[2] <= pb[1];
  end
  assign b_mem_rdata = pb[2] ^ 32'hC0DE_0000;

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        im_req;
    logic [31:0] im_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_im_gnt;
    logic        e_dm_gnt;
    logic        e_im_rv;
    logic [31:0] e_im_rdata;
    logic        e_dm_rv;
    logic [31:0] e_dm_rdata;
    logic        e_req;
    logic        e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic imr, input logic [31:0] ima,
                              input logic dmr, input logic dmw, input logic [3:0] dmb,
                              input logic [31:0] dma, input logic [31:0] dmd,
                              input logic eig, input logic edg, input logic eiv, input logic [31:0] eid,
                              input logic edv, input logic [31:0] edd, input logic erq, input logic ewe,
                              input logic [3:0] ebe, input logic [31:0] ead, input logic [31:0] ewd);
    vec_t v;
    v.name = nm; v.im_req = imr; v.im_addr = ima; v.dm_req = dmr; v.dm_we = dmw;
    v.dm_be = dmb; v.dm_addr = dma; v.dm_wdata = dmd;
    v.e_im_gnt = eig; v.e_dm_gnt = edg; v.e_im_rv = eiv; v.e_im_rdata = eid;
    v.e_dm_rv = edv; v.e_dm_rdata = edd; v.e_req = erq; v.e_we = ewe;
    v.e_be = ebe; v.e_addr = ead; v.e_wdata = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input vec_t v);
    chk({v.name, ".im_gnt"},    32'(a_im_gnt),    32'(v.e_im_gnt));
    chk({v.name, ".dm_gnt"},    32'(a_dm_gnt),    32'(v.e_dm_gnt));
    chk({v.name, ".im_rvalid"}, 32'(a_im_rvalid), 32'(v.e_im_rv));
    chk({v.name, ".im_rdata"},  a_im_rdata,       v.e_im_rdata);
    chk({v.name, ".dm_rvalid"}, 32'(a_dm_rvalid), 32'(v.e_dm_rv));
    chk({v.name, ".dm_rdata"},  a_dm_rdata,       v.e_dm_rdata);
    chk({v.name, ".mem_req"},   32'(a_mem_req),   32'(v.e_req));
    chk({v.name, ".mem_we"},    32'(a_mem_we),    32'(v.e_we));
    chk({v.name, ".mem_be"},    32'(a_mem_be),    32'(v.e_be));
    chk({v.name, ".mem_addr"},  a_mem_addr,       v.e_addr);
    chk({v.name, ".mem_wdata"}, a_mem_wdata,      v.e_wdata);
  endtask

  task automatic drive_a(input logic imr, input logic [31:0] ima, input logic dmr, input logic dmw,
                         input logic [3:0] dmb, input logic [31:0] dma, input logic [31:0] dmd);
    a_im_req = imr; a_im_addr = ima; a_dm_req = dmr; a_dm_we = dmw;
    a_dm_be = dmb; a_dm_addr = dma; a_dm_wdata = dmd;
  endtask

  initial begin
    // idle, fetch read latency 2, back-to-back fetch, dm over im, dm read be forced to all ones
    vecs.push_back(mk("idle0",     0, 0,      0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("im_gnt",    1, 'h100, 0, 0, 0, 0, 0,     1, 0, 0, 0,            0, 0,            1, 0, 4'hF, 'h100,  0));
    vecs.push_back(mk("im_nogt",   1, 'h104, 0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("im_rv_gnt", 1, 'h104, 0, 0, 0, 0, 0,     1, 0, 1, 'hC0DE0100,   0, 0,            1, 0, 4'hF, 'h104,  0));
    vecs.push_back(mk("wait_mid",  0, 0,      0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("im_rv2",    0, 0,      0, 0, 0, 0, 0,     0, 0, 1, 'hC0DE0104,   0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("both_dm",   1, 'h200, 1, 0, 4'h3, 'h300, 0, 0, 1, 0, 0,         0, 0,            1, 0, 4'hF, 'h300,  0));
    vecs.push_back(mk("both_wait", 1, 'h200, 0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("dm_rv_im",  1, 'h200, 0, 0, 0, 0, 0,     1, 0, 0, 0,            1, 'hC0DE0300,   1, 0, 4'hF, 'h200,  0));
    vecs.push_back(mk("wait_mid2", 0, 0,      0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("im_rv3",    0, 0,      0, 0, 0, 0, 0,     0, 0, 1, 'hC0DE0200,   0, 0,            0, 0, 4'h0, 0,      0));
    // back-to-back partial writes, one per cycle, never an rvalid
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk($sformatf("wr%0d", i), 0, 0, 1, 1, 4'h3, 32'(i), 'hA5,
                        0, 1, 0, 0, 0, 0, 1, 1, 4'h3, 32'(i), 'hA5));
    vecs.push_back(mk("idle1",     0, 0,      0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));
    // starvation: four dm wins, fetch forced on the fifth, dm back at the next grant slot
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk($sformatf("starve_dm%0d", i), 1, 'h500, 1, 1, 4'hF, 'h40, 'h11,
                        0, 1, 0, 0, 0, 0, 1, 1, 4'hF, 'h40, 'h11));
    vecs.push_back(mk("starve_im", 1, 'h500, 1, 1, 4'hF, 'h40, 'h11, 1, 0, 0, 0,     0, 0,            1, 0, 4'hF, 'h500,  0));
    vecs.push_back(mk("st_wait",   0, 0,      1, 1, 4'hF, 'h40, 'h11, 0, 0, 0, 0,     0, 0,            0, 0, 4'h0, 0,      0));
    vecs.push_back(mk("dm_resume", 0, 0,      1, 1, 4'hF, 'h40, 'h11, 0, 1, 1, 'hC0DE0500, 0, 0,       1, 1, 4'hF, 'h40,   'h11));
    vecs.push_back(mk("dm_again",  0, 0,      1, 1, 4'hF, 'h44, 'h12, 0, 1, 0, 0,     0, 0,            1, 1, 4'hF, 'h44,   'h12));
    vecs.push_back(mk("idle2",     0, 0,      0, 0, 0, 0, 0,     0, 0, 0, 0,            0, 0,            0, 0, 4'h0, 0,      0));

    // reset both instances
    next_cycle();
    next_cycle();
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive_a(vecs[i].im_req, vecs[i].im_addr, vecs[i].dm_req, vecs[i].dm_we,
              vecs[i].dm_be, vecs[i].dm_addr, vecs[i].dm_wdata);
      #3;
      check_a(vecs[i]);
      next_cycle();
    end

    // Mid-run reset on A: build starve count to 2, reset with requests held, outputs must drop.
    drive_a(1, 'h600, 1, 1, 4'hF, 'h48, 'h22);
    for (int i = 0; i < 2; i++) begin
      #3;
      chk($sformatf("pre_rst_dm_gnt%0d", i), 32'(a_dm_gnt), 32'd1);
      next_cycle();
    end
    a_rst_n = 1'b0;
    #1;
    chk("rst_im_gnt",   32'(a_im_gnt),  32'd0);
    chk("rst_dm_gnt",   32'(a_dm_gnt),  32'd0);
    chk("rst_mem_req",  32'(a_mem_req), 32'd0);
    chk("rst_mem_we",   32'(a_mem_we),  32'd0);
    chk("rst_mem_be",   32'(a_mem_be),  32'd0);
    chk("rst_mem_addr", a_mem_addr,     32'd0);
    chk("rst_mem_wdata", a_mem_wdata,   32'd0);
    chk("rst_rvalid",   32'(a_im_rvalid | a_dm_rvalid), 32'd0);
    chk("rst_rdata",    a_im_rdata | a_dm_rdata, 32'd0);
    next_cycle();
    a_rst_n = 1'b1;
    // Starve count cleared: dm should again win four times before fetch.
    for (int i = 0; i < 5; i++) begin
      #3;
      chk($sformatf("post_rst_dm_gnt%0d", i), 32'(a_dm_gnt), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("post_rst_im_gnt%0d", i), 32'(a_im_gnt), (i < 4) ? 32'd0 : 32'd1);
      next_cycle();
    end
    drive_a(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("post_rst_wait", 32'(a_im_rvalid), 32'd0);
    next_cycle();
    #3;
    chk("post_rst_im_rv", 32'(a_im_rvalid), 32'd1);
    chk("post_rst_im_rdata", a_im_rdata, 32'hC0DE0600);
    next_cycle();

    // Reset on B one cycle after a latency-3 read is granted: read is dropped, FSM is IDLE.
    b_im_req = 1'b1; b_im_addr = 32'h700;
    #3;
    chk("b_gnt_T", 32'(b_im_gnt), 32'd1);
    chk("b_addr_T", b_mem_addr, 32'h700);
    next_cycle();
    b_im_req = 1'b0;
    b_rst_n = 1'b0;
    #2;
    b_rst_n = 1'b1;
    chk("b_rv_T1", 32'(b_im_rvalid), 32'd0);
    next_cycle();
    b_im_req = 1'b1; b_im_addr = 32'h704;
    #3;
    chk("b_gnt_idle_T2", 32'(b_im_gnt), 32'd1);
    next_cycle();
    b_im_req = 1'b0;
    #3;
    chk("b_no_rv_T3", 32'(b_im_rvalid), 32'd0);
    chk("b_no_rdata_T3", b_im_rdata, 32'd0);
    next_cycle();
    #3;
    chk("b_no_rv_T4", 32'(b_im_rvalid), 32'd0);
    next_cycle();
    #3;
    chk("b_rv_T5", 32'(b_im_rvalid), 32'd1);
    chk("b_rdata_T5", b_im_rdata, 32'hC0DE0704);
    chk("b_dm_rv_T5", 32'(b_dm_rvalid), 32'd0);
    next_cycle();
    #3;
    chk("b_rv_done", 32'(b_im_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
